// File: rtl/byte_lsu_if.sv
// Core-side request/response and byte-wide RAM port signals of the load/store unit.
// slave: the LSU itself; master: the core plus RAM environment that drives it.
interface byte_lsu_if;
    logic        req;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_uns;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] mem_ra;
    logic [31:0] mem_rd;
    logic        mem_we;
    logic [31:0] mem_wa;
    logic [31:0] mem_wd;

    modport slave (
        input  req, req_we, req_size, req_uns, req_addr, req_wdata, mem_rd,
        output busy, done, err, rdata, mem_ra, mem_we, mem_wa, mem_wd
    );

    modport master (
        output req, req_we, req_size, req_uns, req_addr, req_wdata, mem_rd,
        input  busy, done, err, rdata, mem_ra, mem_we, mem_wa, mem_wd
    );
endinterface

// File: rtl/byte_lsu.sv
// Byte-serial load/store unit: one RAM byte per clock, done n+1 cycles after accept; req ignored unless IDLE.
// MISALIGN_TRAP_EN: misaligned half/word skips memory and returns done+err one cycle after accept.
module byte_lsu #(
    parameter int ADDR_BITS = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    byte_lsu_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_we;
    logic                   r_uns;
    logic [1:0]             r_size;
    logic [1:0]             r_cnt;
    logic [1:0]             r_last;
    logic [ADDR_BITS-1:0]   r_addr;
    logic [31:0]            r_wdata;
    logic [31:0]            r_asm;
    logic [31:0]            r_rdata;
    logic                   w_accept;
    logic                   w_trap;
    logic                   w_last;
    logic [ADDR_BITS-1:0]   w_cur_addr;
    logic [31:0]            w_asm_nxt;
    logic [31:0]            w_ext;
    logic                   w_unused;

`ifdef MISALIGN_TRAP_EN
    logic                   r_err;
    logic                   w_misalign;
    assign w_misalign = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                        (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));
    assign w_trap     = w_misalign;
    assign bus.err    = (r_state == DONE) && r_err;
`else
    assign w_trap     = 1'b0;
    assign bus.err    = 1'b0;
`endif

    assign w_unused   = ^{bus.mem_rd[31:8], bus.req_addr[31:ADDR_BITS]};
    assign w_accept   = (r_state == IDLE) && bus.req;
    assign w_last     = (r_cnt == r_last);
    // Address arithmetic stays ADDR_BITS wide so carries wrap inside the RAM.
    assign w_cur_addr = r_addr + {{(ADDR_BITS-2){1'b0}}, r_cnt};

    always_comb begin
        w_asm_nxt = r_asm;
        w_asm_nxt[{r_cnt, 3'b000} +: 8] = bus.mem_rd[7:0];
    end

    always_comb begin
        w_ext = w_asm_nxt;
        case (r_size)
            2'b00:   w_ext = {{24{~r_uns & w_asm_nxt[7]}},  w_asm_nxt[7:0]};
            2'b01:   w_ext = {{16{~r_uns & w_asm_nxt[15]}}, w_asm_nxt[15:0]};
            default: w_ext = w_asm_nxt;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.req) w_state_nxt = w_trap ? DONE : XFER;
            XFER:    if (w_last)  w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_uns   <= 1'b0;
            r_size  <= 2'b00;
            r_cnt   <= 2'b00;
            r_last  <= 2'b00;
            r_addr  <= '0;
            r_wdata <= '0;
            r_asm   <= '0;
            r_rdata <= '0;
`ifdef MISALIGN_TRAP_EN
            r_err   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_we    <= bus.req_we;
            r_uns   <= bus.req_uns;
            r_size  <= bus.req_size;
            r_cnt   <= 2'b00;
            r_last  <= (bus.req_size == 2'b00) ? 2'd0 :
                       (bus.req_size == 2'b01) ? 2'd1 : 2'd3;
            r_addr  <= bus.req_addr[ADDR_BITS-1:0];
            r_wdata <= bus.req_wdata;
            r_asm   <= '0;
`ifdef MISALIGN_TRAP_EN
            r_err   <= w_misalign;
`endif
        end else if (r_state == XFER) begin
            r_cnt <= r_cnt + 2'd1;
            if (!r_we) begin
                r_asm <= w_asm_nxt;
                // Result registers on the last byte edge so it is visible during DONE.
                if (w_last) r_rdata <= w_ext;
            end
        end
    end

    assign bus.busy   = (r_state == XFER);
    assign bus.done   = (r_state == DONE);
    assign bus.rdata  = r_rdata;
    assign bus.mem_we = (r_state == XFER) && r_we;
    assign bus.mem_ra = {{(32-ADDR_BITS){1'b0}}, w_cur_addr};
    assign bus.mem_wa = {{(32-ADDR_BITS){1'b0}}, w_cur_addr};
    assign bus.mem_wd = {24'b0, r_wdata[{r_cnt, 3'b000} +: 8]};
endmodule

// File: tb/tb_byte_lsu.sv
// Scoreboard bench for byte_lsu: stimulus queues expected done/write events, a negedge monitor checks them.
module tb_byte_lsu;
    typedef struct {
        int          cyc;
        logic [31:0] rd;
        logic        er;
    } done_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic        clk;
    logic        rst_n;
    int          cyc;
    int          n_chk;
    int          n_fail;
    logic [31:0] last_rd;
    done_t       dq[$];
    wr_t         wq[$];
    logic [7:0]  ram [0:511] = '{default: 8'h00};

    byte_lsu_if bus();

    byte_lsu #(.ADDR_BITS(9)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: combinational read with junk in the unused upper bits, clocked write.
    assign bus.mem_rd = {24'hA5A5A5, ram[bus.mem_ra[8:0]]};
    always @(posedge clk) if (bus.mem_we) ram[bus.mem_wa[8:0]] <= bus.mem_wd[7:0];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        done_t e;
        wr_t   w;
        if (rst_n) begin
            if (bus.done) begin
                if (dq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done with rdata %h, required none", bus.rdata);
                end else begin
                    e = dq.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("rdata", bus.rdata, e.rd);
                    chk("err", {31'b0, bus.err}, {31'b0, e.er});
                end
            end
            if (bus.mem_we) begin
                if (wq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_write: got %h<=%h, required no write", bus.mem_wa, bus.mem_wd);
                end else begin
                    w = wq.pop_front();
                    chk("wr_addr", bus.mem_wa, w.a);
                    chk("wr_data", bus.mem_wd, w.d);
                end
            end
        end
    end

    task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        wq.push_back(w);
    endtask

    // nb = memory cycles expected (0 for a trapped access); pulse re-raises req while busy.
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err,
                          input int nb, input logic pulse);
        done_t e;
        @(negedge clk);
        rst_n         = 1'b1;
        bus.req       = 1'b1;
        bus.req_we    = we;
        bus.req_size  = sz;
        bus.req_uns   = uns;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        e.cyc = cyc + nb + 1;
        e.rd  = exp_rd;
        e.er  = exp_err;
        dq.push_back(e);
        last_rd = exp_rd;
        for (int k = 1; k <= nb + 2; k++) begin
            @(negedge clk);
            bus.req = pulse && (k <= 2);
            if (k == 1) begin
                bus.req_wdata = ~wd;
                bus.req_addr  = 32'h0;
                chk("busy_after_accept", {31'b0, bus.busy}, {31'b0, nb > 0});
            end
        end
    endtask

    initial begin
        n_chk         = 0;
        n_fail        = 0;
        last_rd       = 32'h0;
        rst_n         = 1'b0;
        bus.req       = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_size  = 2'b00;
        bus.req_uns   = 1'b0;
        bus.req_addr  = 32'h010;
        bus.req_wdata = 32'h5A;
        repeat (3) @(negedge clk);
        chk("rst_busy",   {31'b0, bus.busy},   32'h0);
        chk("rst_done",   {31'b0, bus.done},   32'h0);
        chk("rst_err",    {31'b0, bus.err},    32'h0);
        chk("rst_mem_we", {31'b0, bus.mem_we}, 32'h0);
        chk("rst_rdata",  bus.rdata,  32'h0);
        chk("rst_mem_ra", bus.mem_ra, 32'h0);
        chk("rst_mem_wa", bus.mem_wa, 32'h0);
        chk("rst_mem_wd", bus.mem_wd, 32'h0);

        exp_wr(32'h010, 32'h5A);
        do_req(1'b1, 2'b00, 1'b0, 32'h010, 32'h5A, last_rd, 1'b0, 1, 1'b0);

        exp_wr(32'h1FC, 32'h78); exp_wr(32'h1FD, 32'h56);
        exp_wr(32'h1FE, 32'h34); exp_wr(32'h1FF, 32'h12);
        do_req(1'b1, 2'b10, 1'b0, 32'h1FC, 32'h12345678, last_rd, 1'b0, 4, 1'b0);

        exp_wr(32'h1FD, 32'h80);
        do_req(1'b1, 2'b00, 1'b0, 32'h1FD, 32'hFFFFFF80, last_rd, 1'b0, 1, 1'b0);
        do_req(1'b0, 2'b00, 1'b0, 32'h1FD, 32'h0, 32'hFFFFFF80, 1'b0, 1, 1'b0);
        do_req(1'b0, 2'b00, 1'b1, 32'h1FD, 32'h0, 32'h00000080, 1'b0, 1, 1'b0);
        do_req(1'b0, 2'b01, 1'b0, 32'h1FE, 32'h0, 32'h00001234, 1'b0, 2, 1'b0);
        do_req(1'b0, 2'b01, 1'b0, 32'h1FC, 32'h0, 32'hFFFF8078, 1'b0, 2, 1'b0);
        do_req(1'b0, 2'b11, 1'b0, 32'h1FC, 32'h0, 32'h12348078, 1'b0, 4, 1'b0);
        do_req(1'b0, 2'b00, 1'b1, 32'hFFFFFE10, 32'h0, 32'h0000005A, 1'b0, 1, 1'b0);

`ifdef MISALIGN_TRAP_EN
        do_req(1'b1, 2'b01, 1'b0, 32'h1FF, 32'h1234BEEF, last_rd, 1'b1, 0, 1'b0);
        do_req(1'b0, 2'b01, 1'b1, 32'h1FF, 32'h0, last_rd, 1'b1, 0, 1'b0);
`else
        exp_wr(32'h1FF, 32'hEF); exp_wr(32'h000, 32'hBE);
        do_req(1'b1, 2'b01, 1'b0, 32'h1FF, 32'h1234BEEF, last_rd, 1'b0, 2, 1'b0);
        do_req(1'b0, 2'b01, 1'b1, 32'h1FF, 32'h0, 32'h0000BEEF, 1'b0, 2, 1'b0);
`endif

        exp_wr(32'h100, 32'hD4); exp_wr(32'h101, 32'hC3);
        exp_wr(32'h102, 32'hB2); exp_wr(32'h103, 32'hA1);
        do_req(1'b1, 2'b10, 1'b0, 32'h100, 32'hA1B2C3D4, last_rd, 1'b0, 4, 1'b0);
`ifdef MISALIGN_TRAP_EN
        do_req(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, last_rd, 1'b1, 0, 1'b0);
`else
        do_req(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'h00A1B2C3, 1'b0, 4, 1'b0);
`endif

        exp_wr(32'h040, 32'h0D); exp_wr(32'h041, 32'hF0);
        exp_wr(32'h042, 32'hAD); exp_wr(32'h043, 32'h0B);
        do_req(1'b1, 2'b10, 1'b0, 32'h040, 32'h0BADF00D, last_rd, 1'b0, 4, 1'b1);

        // Abort a word store after its second byte has been written.
        @(negedge clk);
        bus.req       = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_size  = 2'b10;
        bus.req_addr  = 32'h020;
        bus.req_wdata = 32'hCAFEF00D;
        exp_wr(32'h020, 32'h0D); exp_wr(32'h021, 32'hF0);
        @(negedge clk);
        bus.req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_mem_we", {31'b0, bus.mem_we}, 32'h0);
        chk("abort_busy",   {31'b0, bus.busy},   32'h0);
        @(negedge clk);
        chk("abort_ram20", {24'b0, ram[9'h020]}, 32'h0D);
        chk("abort_ram21", {24'b0, ram[9'h021]}, 32'hF0);
        chk("abort_ram22", {24'b0, ram[9'h022]}, 32'h00);
        chk("abort_rdata", bus.rdata, 32'h0);
        last_rd = 32'h0;
        do_req(1'b0, 2'b00, 1'b1, 32'h021, 32'h0, 32'h000000F0, 1'b0, 1, 1'b0);

        repeat (3) @(negedge clk);
        chk("pending_done",  dq.size(), 32'h0);
        chk("pending_write", wq.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
